// File: rtl/fb_write_sender.sv
// fb_write_sender: queues framebuffer writes and paces them for an unhandshaked CDC.
// Optional vblank gating of pops: define FB_SEND_VBLANK_GATE_EN.
module fb_write_sender #(
  parameter int FIFO_DEPTH   = 8,
  parameter int SETUP_CYCLES = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                          clk_cpu_fast,
  input  logic                          rst_cpu_n,
  input  logic                          wr_valid,
  input  logic [11:0]                   wr_addr,
  input  logic [11:0]                   wr_data,
  output logic                          wr_ready,
  input  logic                          cpu_vblank,
  output logic [11:0]                   cpu_fb_addr,
  output logic [11:0]                   cpu_fb_data,
  output logic                          cpu_fb_we,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          wr_overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int MX0 = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MX  = (MX0 > GAP_CYCLES) ? MX0 : GAP_CYCLES;
  localparam int CW  = $clog2(MX) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   addr_q, addr_d;
  logic [11:0]   data_q, data_d;
  logic          we_q, we_d;
  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic          ovf_q, ovf_d;
  logic [23:0]   mem_q [FIFO_DEPTH];

  logic gate_open;
  logic push;
  logic pop;

`ifdef FB_SEND_VBLANK_GATE_EN
  assign gate_open = cpu_vblank;
`else
  logic unused_vblank;
  assign unused_vblank = cpu_vblank;
  assign gate_open     = 1'b1;
`endif

  assign wr_ready = (level_q != LW'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (state_q == IDLE) && (level_q != '0) && gate_open;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    level_d = level_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ovf_d   = ovf_q | (wr_valid & ~wr_ready);

    if (push) wr_d = wr_q + AW'(1);
    if (pop) begin
      rd_d   = rd_q + AW'(1);
      addr_d = mem_q[rd_q][23:12];
      data_d = mem_q[rd_q][11:0];
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Each state runs its down-counter to zero, then hands over.
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          we_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CW'(GAP_CYCLES - 1);
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu_fast) begin
    if (!rst_cpu_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      level_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      level_q <= level_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_cpu_fast) begin
    if (push) mem_q[wr_q] <= {wr_addr, wr_data};
  end

  assign cpu_fb_addr = addr_q;
  assign cpu_fb_data = data_q;
  assign cpu_fb_we   = we_q;
  assign fifo_level  = level_q;
  assign wr_overflow = ovf_q;
  assign busy        = (state_q != IDLE) || (level_q != '0);

endmodule
